// File: rtl/alu_ctrl_stage_if.sv
// Bundles the ID->EX decode request, hazard controls and the registered ALU-control results.
// Latency: none; this is a pure signal bundle.
// Backpressure: stall_req flows back to the master; stall_in/flush flow forward to the stage.
interface alu_ctrl_stage_if #(
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 2,
    parameter int CTRL_W  = 4
);
    logic               id_valid;
    logic [ALUOP_W-1:0] alu_op;
    logic [FUNCT_W-1:0] funct;
    logic               stall_in;
    logic               flush;

    logic               ex_valid;
    logic [CTRL_W-1:0]  alu_ctrl;
    logic               illegal;
    logic               mdu_start;
    logic               mdu_done;
    logic               stall_req;

    // ID/hazard side: drives the request, observes the EX register
    modport master (
        output id_valid, alu_op, funct, stall_in, flush,
        input  ex_valid, alu_ctrl, illegal, mdu_start, mdu_done, stall_req
    );

    // ALU-control stage side
    modport slave (
        input  id_valid, alu_op, funct, stall_in, flush,
        output ex_valid, alu_ctrl, illegal, mdu_start, mdu_done, stall_req
    );
endinterface

// File: rtl/alu_ctrl_stage.sv
// ALU-control decode register at the ID/EX boundary, with a MUL/DIV issue/busy sequencer.
// Latency: decoded control word visible 1 cycle after capture; MUL/DIV busy for MDU_LATENCY cycles.
// Backpressure: holds on stall_in or while busy (stall_req=1); flush overrides everything.
// Optional: define ALUCTRL_SRA_EN to decode funct 000011 as SRA (otherwise illegal).
module alu_ctrl_stage #(
    parameter int FUNCT_W     = 6,
    parameter int ALUOP_W     = 2,
    parameter int CTRL_W      = 4,
    parameter int MDU_LATENCY = 4
) (
    input  logic          clk,
    input  logic          reset,
    alu_ctrl_stage_if.slave bus
);

    // FSM encoding
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    // ALU control encodings, zero-extended to CTRL_W
    localparam logic [CTRL_W-1:0] C_AND = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] C_OR  = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] C_ADD = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] C_SLL = CTRL_W'(4'b0011);
    localparam logic [CTRL_W-1:0] C_SRL = CTRL_W'(4'b0100);
    localparam logic [CTRL_W-1:0] C_XOR = CTRL_W'(4'b0101);
    localparam logic [CTRL_W-1:0] C_SUB = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] C_SLT = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] C_MUL = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] C_DIV = CTRL_W'(4'b1001);
`ifdef ALUCTRL_SRA_EN
    localparam logic [CTRL_W-1:0] C_SRA = CTRL_W'(4'b1010);
`endif
    localparam logic [CTRL_W-1:0] C_NOR = CTRL_W'(4'b1100);
    localparam logic [CTRL_W-1:0] C_NOP = CTRL_W'(4'b1111);

    // ALUOp values from main control
    localparam logic [ALUOP_W-1:0] OP_LS    = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] OP_BEQ   = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] OP_RTYPE = ALUOP_W'(2'b10);
    localparam logic [ALUOP_W-1:0] OP_ORI   = ALUOP_W'(2'b11);

    // R-type funct codes
    localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] F_AND = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] F_OR  = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] F_XOR = FUNCT_W'(6'b100110);
    localparam logic [FUNCT_W-1:0] F_NOR = FUNCT_W'(6'b100111);
    localparam logic [FUNCT_W-1:0] F_SLT = FUNCT_W'(6'b101010);
    localparam logic [FUNCT_W-1:0] F_SLL = FUNCT_W'(6'b000000);
    localparam logic [FUNCT_W-1:0] F_SRL = FUNCT_W'(6'b000010);
`ifdef ALUCTRL_SRA_EN
    localparam logic [FUNCT_W-1:0] F_SRA = FUNCT_W'(6'b000011);
`endif
    localparam logic [FUNCT_W-1:0] F_MUL = FUNCT_W'(6'b011000);
    localparam logic [FUNCT_W-1:0] F_DIV = FUNCT_W'(6'b011010);

    // 8-bit counter covers the full 2..255 latency range
    localparam logic [7:0] CNT_LOAD = 8'(MDU_LATENCY - 1);

    logic [0:0]        r_state;
    logic [7:0]        r_cnt;
    logic              r_ex_valid;
    logic [CTRL_W-1:0] r_alu_ctrl;
    logic              r_illegal;
    logic              r_mdu_start;

    logic [CTRL_W-1:0] w_dec_ctrl;
    logic              w_dec_illegal;
    logic              w_dec_mdu;
    logic              w_busy;
    logic              w_hold;
    logic              w_issue;

    // Combinational ALUOp/funct decode of the instruction currently in ID
    always_comb begin
        w_dec_ctrl    = C_NOP;
        w_dec_illegal = 1'b0;
        case (bus.alu_op)
            OP_LS:  w_dec_ctrl = C_ADD;
            OP_BEQ: w_dec_ctrl = C_SUB;
            OP_ORI: w_dec_ctrl = C_OR;
            OP_RTYPE: begin
                case (bus.funct)
                    F_ADD:   w_dec_ctrl = C_ADD;
                    F_SUB:   w_dec_ctrl = C_SUB;
                    F_AND:   w_dec_ctrl = C_AND;
                    F_OR:    w_dec_ctrl = C_OR;
                    F_XOR:   w_dec_ctrl = C_XOR;
                    F_NOR:   w_dec_ctrl = C_NOR;
                    F_SLT:   w_dec_ctrl = C_SLT;
                    F_SLL:   w_dec_ctrl = C_SLL;
                    F_SRL:   w_dec_ctrl = C_SRL;
`ifdef ALUCTRL_SRA_EN
                    F_SRA:   w_dec_ctrl = C_SRA;
`endif
                    F_MUL:   w_dec_ctrl = C_MUL;
                    F_DIV:   w_dec_ctrl = C_DIV;
                    default: begin
                        w_dec_ctrl    = C_NOP;
                        w_dec_illegal = 1'b1;
                    end
                endcase
            end
            default: w_dec_ctrl = C_NOP;
        endcase
    end

    assign w_dec_mdu = (w_dec_ctrl == C_MUL) || (w_dec_ctrl == C_DIV);
    assign w_busy    = (r_state == S_BUSY);
    assign w_hold    = bus.stall_in || w_busy;
    // A MUL/DIV only issues on a real capture: no flush, no hold, valid instruction
    assign w_issue   = !bus.flush && !w_hold && bus.id_valid && w_dec_mdu;

    // EX pipeline register: flush beats hold beats capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid  <= 1'b0;
            r_alu_ctrl  <= C_NOP;
            r_illegal   <= 1'b0;
            r_mdu_start <= 1'b0;
        end else if (bus.flush) begin
            r_ex_valid  <= 1'b0;
            r_alu_ctrl  <= C_NOP;
            r_illegal   <= 1'b0;
            r_mdu_start <= 1'b0;
        end else if (w_hold) begin
            r_mdu_start <= 1'b0;
        end else begin
            r_ex_valid  <= bus.id_valid;
            r_alu_ctrl  <= bus.id_valid ? w_dec_ctrl : C_NOP;
            r_illegal   <= bus.id_valid & w_dec_illegal;
            r_mdu_start <= w_issue;
        end
    end

    // MUL/DIV sequencer: counter runs free of stall_in, only flush aborts it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else if (w_busy) begin
            if (r_cnt == 8'd0) begin
                r_state <= S_IDLE;
            end else begin
                r_cnt <= r_cnt - 8'd1;
            end
        end else if (w_issue) begin
            r_state <= S_BUSY;
            r_cnt   <= CNT_LOAD;
        end
    end

    assign bus.ex_valid  = r_ex_valid;
    assign bus.alu_ctrl  = r_alu_ctrl;
    assign bus.illegal   = r_illegal;
    assign bus.mdu_start = r_mdu_start;
    assign bus.mdu_done  = w_busy && (r_cnt == 8'd0);
    assign bus.stall_req = w_busy;

endmodule
